mod_cipher_stream: RTL
======================

MOD_CIPHER_STREAM -- requirements
Module: mod_cipher_stream

Interface
REQ-001 Parameter DATA_W, 8, character/key width in bits.
REQ-002 Parameter P_MOD, 227, modulus; SHALL satisfy CHAR_HI < P_MOD < 2^DATA_W.
REQ-003 Parameter CHAR_LO, 8'h61, lowest legal plaintext code.
REQ-004 Parameter CHAR_HI, 8'h7A, highest legal plaintext code.
REQ-005 Parameter FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 mode  in  2  2'b01 encrypt, 2'b10 decrypt, 2'b00/2'b11 illegal; sampled with each accepted character.
REQ-009 key_in  in  DATA_W  key value to load.
REQ-010 key_load  in  1  one-cycle load strobe for key_in.
REQ-011 flush  in  1  synchronous clear of FIFO contents.
REQ-012 in_data  in  DATA_W  plaintext character.
REQ-013 in_valid  in  1  in_data/mode valid.
REQ-014 in_ready  out  1  block can accept a character this cycle.
REQ-015 out_data  out  DATA_W  FIFO head character.
REQ-016 out_valid  out  1  FIFO non-empty.
REQ-017 out_ready  in  1  consumer accepts out_data.
REQ-018 key_ok  out  1  a legal key is loaded (FSM in RUN).
REQ-019 err_invalid_ptxt  out  1  one-cycle pulse per rejected character.
REQ-020 err_cnt  out  8  saturating count of rejected characters.
REQ-021 fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-022 FSM SHALL have states NO_KEY and RUN; key_load with key_in < P_MOD SHALL latch the key and enter/stay RUN; key_load with key_in >= P_MOD SHALL leave the key register unchanged and enter NO_KEY.
REQ-023 key_ok SHALL be 1 exactly when in RUN; a key change SHALL affect only characters accepted after the load edge, never FIFO contents.
REQ-024 in_ready SHALL be 1 iff state is RUN, flush=0, key_load=0, and (FIFO not full or out_valid && out_ready in the same cycle).
REQ-025 A character is accepted on a rising edge with in_valid && in_ready; in_valid while in_ready=0 SHALL have no effect.
REQ-026 An accepted character SHALL be rejected when in_data < CHAR_LO, in_data > CHAR_HI, or mode is illegal: no FIFO write, err_invalid_ptxt=1 for the following cycle, err_cnt+1 saturating at 255.
REQ-027 Encrypt result SHALL be (in_data + key) mod P_MOD; decrypt result SHALL be (in_data - key) mod P_MOD, computed in DATA_W+1 bits with one conditional +P_MOD (negative) or -P_MOD (>= P_MOD) correction; result always in [0, P_MOD-1].
REQ-028 A legal accepted character SHALL be written to the FIFO at the accepting edge; out_valid SHALL rise the cycle after acceptance when the FIFO was empty (latency 1).
REQ-029 FIFO pop SHALL occur on a rising edge with out_valid && out_ready; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 Simultaneous push and pop SHALL leave fifo_count unchanged, including when full; order SHALL be strictly first-in first-out; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 flush SHALL empty the FIFO and clear err_cnt at the next edge, keep the key and FSM state, and take priority over any push/pop that cycle.
REQ-032 key_load and flush in the same cycle SHALL both take effect.

Reset
REQ-033 On rst_n=0, immediately and independent of clk: state NO_KEY, key register 0, FIFO empty, fifo_count 0, out_valid 0, out_data 0, in_ready 0, key_ok 0, err_invalid_ptxt 0, err_cnt 0.
REQ-034 Reset mid-stream SHALL discard all FIFO contents; after release, no character is accepted until a legal key_load.

Verification
REQ-035 Load key 8'h05, decrypt 8'h61 -> out_data 8'h5C, out_valid one cycle after acceptance; load 8'hC8, decrypt 8'h61 -> 8'h7C (negative wrap).
REQ-036 Load key 8'h7F, encrypt 8'h7A -> 8'h16 (249-227); load 8'hE3 -> key_ok=0, in_ready=0, key register unchanged.
REQ-037 out_ready=0, push 8'h61..8'h64 with key 8'h01 decrypt -> fifo_count 4, in_ready=0; then out_ready=1 with in_valid=1 -> push+pop same cycle, count stays 4, outputs 8'h60,8'h61,8'h62,8'h63 in order.
REQ-038 Send 8'h41 and mode 2'b00 with 8'h62 -> no FIFO write, two err_invalid_ptxt pulses, err_cnt=2; 300 bad characters -> err_cnt=255.
REQ-039 FIFO holding 3 entries, assert rst_n=0 mid-cycle -> out_valid=0, fifo_count=0 immediately; in_ready stays 0 until a legal key_load.
REQ-040 flush with 2 entries and key_load 8'h10 same cycle -> FIFO empty, err_cnt 0, key_ok=1, next decrypt 8'h70 -> 8'h60.

Source files
------------

// File: rtl/mod_cipher_stream_if.sv
// Stream interface for mod_cipher_stream: character input side and FIFO output side.
interface mod_cipher_stream_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        mode;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // Producer/consumer side (drives characters, accepts results)
    modport master (
        output mode, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // Cipher block side
    modport slave (
        input  mode, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/mod_cipher_stream.sv
// Modular add/subtract stream cipher with key FSM, plaintext range check,
// saturating reject counter and a small output FIFO.
module mod_cipher_stream #(
    parameter int                DATA_W     = 8,
    parameter int                P_MOD      = 227,
    parameter logic [DATA_W-1:0] CHAR_LO    = 8'h61,
    parameter logic [DATA_W-1:0] CHAR_HI    = 8'h7A,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_W-1:0]               key_in,
    input  logic                            key_load,
    input  logic                            flush,
    mod_cipher_stream_if.slave              bus,
    output logic                            key_ok,
    output logic                            err_invalid_ptxt,
    output logic [7:0]                      err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DATA_W:0] P_MOD_W = (DATA_W+1)'(P_MOD);

    typedef enum logic {ST_NO_KEY = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_r;
    logic [DATA_W-1:0] key_r;
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              err_pulse_r;
    logic [7:0]        err_cnt_r;

    logic              full_s;
    logic              out_valid_s;
    logic              pop_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              legal_s;
    logic              push_s;
    logic              reject_s;
    logic [DATA_W-1:0] result_s;

    // One conditional correction keeps the DATA_W+1 bit result in [0, P_MOD-1].
    function automatic logic [DATA_W-1:0] cipher_f(
        input logic [DATA_W-1:0] ch,
        input logic [DATA_W-1:0] key,
        input logic              dec
    );
        logic [DATA_W:0] t;
        if (dec) begin
            t = {1'b0, ch} - {1'b0, key};
            if (t[DATA_W]) begin
                t = t + P_MOD_W;
            end else if (t >= P_MOD_W) begin
                t = t - P_MOD_W;
            end else begin
                t = t;
            end
        end else begin
            t = {1'b0, ch} + {1'b0, key};
            if (t >= P_MOD_W) begin
                t = t - P_MOD_W;
            end else begin
                t = t;
            end
        end
        return t[DATA_W-1:0];
    endfunction

    // Handshake decode, legality check and cipher datapath.
    always_comb begin
        full_s      = (count_r == CW'(FIFO_DEPTH));
        out_valid_s = (count_r != {CW{1'b0}});
        pop_s       = out_valid_s && bus.out_ready;
        in_ready_s  = (state_r == ST_RUN) && !flush && !key_load && (!full_s || pop_s);
        accept_s    = bus.in_valid && in_ready_s;
        legal_s     = (bus.in_data >= CHAR_LO) && (bus.in_data <= CHAR_HI) &&
                      ((bus.mode == 2'b01) || (bus.mode == 2'b10));
        push_s      = accept_s && legal_s;
        reject_s    = accept_s && !legal_s;
        result_s    = cipher_f(bus.in_data, key_r, bus.mode == 2'b10);
    end

    // Key FSM, FIFO pointers/occupancy and reject bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_NO_KEY;
            key_r       <= {DATA_W{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            err_pulse_r <= 1'b0;
            err_cnt_r   <= 8'd0;
        end else begin
            if (key_load) begin
                if ({1'b0, key_in} < P_MOD_W) begin
                    key_r   <= key_in;
                    state_r <= ST_RUN;
                end else begin
                    state_r <= ST_NO_KEY;
                end
            end else begin
                state_r <= state_r;
            end

            err_pulse_r <= reject_s;

            if (flush) begin
                wr_ptr_r  <= {AW{1'b0}};
                rd_ptr_r  <= {AW{1'b0}};
                count_r   <= {CW{1'b0}};
                err_cnt_r <= 8'd0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
                if (reject_s && (err_cnt_r != 8'hFF)) begin
                    err_cnt_r <= err_cnt_r + 8'd1;
                end
            end
        end
    end

    // FIFO storage write; contents are only visible through the occupancy gate.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= result_s;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_s;
    assign bus.out_data     = out_valid_s ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign key_ok           = (state_r == ST_RUN);
    assign err_invalid_ptxt = err_pulse_r;
    assign err_cnt          = err_cnt_r;
    assign fifo_count       = count_r;
endmodule
